// File: rtl/truth_table_sweep.sv
// truth_table_sweep: drives all eight input combinations of a 3-input gate,
// holds each one for SETTLE_CYCLES+1 cycles, and samples the gate output at
// the end of each hold. The samples are packed into a truth-table word (row 000
// is bit 7) and compared against EXPECTED.
module truth_table_sweep #(
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [7:0]  EXPECTED      = 8'h55
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       gate_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_word,
    output logic       pass,
    output logic [7:0] mismatch_mask
);

    localparam int              CW        = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]   HOLD_LAST = CW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_k;
    logic [2:0]    w_k_next;
    logic [CW-1:0] r_hold;
    logic [CW-1:0] w_hold_next;
    logic [7:0]    r_capture;
    logic [7:0]    w_capture_next;
    logic [2:0]    w_bit_idx;

    logic [2:0]    r_vec;
    logic          r_busy;
    logic          r_done;
    logic [7:0]    r_table;
    logic          r_pass;
    logic [7:0]    r_mask;

    // Row k lands in capture bit 7-k so that row 000 is the MSB.
    assign w_bit_idx = 3'd7 - r_k;

    // Next-state, vector index, hold counter and capture-register update.
    always_comb begin
        w_state_next   = r_state;
        w_k_next       = r_k;
        w_hold_next    = r_hold;
        w_capture_next = r_capture;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next   = DRIVE;
                    w_k_next       = '0;
                    w_hold_next    = '0;
                    w_capture_next = '0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    w_state_next   = IDLE;
                    w_k_next       = '0;
                    w_hold_next    = '0;
                    w_capture_next = '0;
                end else if (r_hold == HOLD_LAST) begin
                    w_capture_next[w_bit_idx] = gate_out;
                    w_hold_next               = '0;
                    if (r_k == 3'd7) begin
                        w_state_next = DONE;
                        w_k_next     = '0;
                    end else begin
                        w_k_next = r_k + 3'd1;
                    end
                end else begin
                    w_hold_next = r_hold + CW'(1);
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register plus outputs registered from the next state, so the
    // vector, busy and done all change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_hold    <= '0;
            r_capture <= '0;
            r_vec     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_table   <= '0;
            r_pass    <= 1'b0;
            r_mask    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_k       <= w_k_next;
            r_hold    <= w_hold_next;
            r_capture <= w_capture_next;
            r_vec     <= (w_state_next == DRIVE) ? w_k_next : 3'd0;
            r_busy    <= (w_state_next == DRIVE);
            r_done    <= (w_state_next == DONE);
            if (w_state_next == DONE) begin
                r_table <= w_capture_next;
                r_pass  <= (w_capture_next == EXPECTED);
                r_mask  <= w_capture_next ^ EXPECTED;
            end
        end
    end

    assign {in1, in2, in3} = r_vec;
    assign busy            = r_busy;
    assign done            = r_done;
    assign table_word      = r_table;
    assign pass            = r_pass;
    assign mismatch_mask   = r_mask;

endmodule
